// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: evaluates conditional branches, trains a 2-bit bimodal BHT,
// raises a registered redirect on mispredict and keeps branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            res_valid,
  input  logic [31:0]     res_inst,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  output logic            res_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            stats_clr,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int unsigned IdxW   = $clog2(BHT_DEPTH);
  localparam logic [31:0] CntMax = '1;

  logic [1:0]      bht_q [BHT_DEPTH];
  logic [IdxW-1:0] if_idx, res_idx;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_br, mispredict;
  logic [1:0]      ctr_cur, ctr_next;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     branch_cnt_q, mispred_cnt_q;
  logic            unused_bits;

  assign opcode  = res_inst[6:0];
  assign funct3  = res_inst[14:12];
  assign if_idx  = if_pc[IdxW+1:2];
  assign res_idx = res_pc[IdxW+1:2];

  assign is_br = res_valid && (opcode == 7'b1100011) && (funct3 != 3'b010) && (funct3 != 3'b011);

  always_comb begin
    res_taken = 1'b0;
    if (is_br) begin
      unique case (funct3)
        3'b000:  res_taken = (res_rs1 == res_rs2);
        3'b001:  res_taken = (res_rs1 != res_rs2);
        3'b100:  res_taken = ($signed(res_rs1) <  $signed(res_rs2));
        3'b101:  res_taken = ($signed(res_rs1) >= $signed(res_rs2));
        3'b110:  res_taken = (res_rs1 <  res_rs2);
        3'b111:  res_taken = (res_rs1 >= res_rs2);
        default: res_taken = 1'b0;
      endcase
    end
  end

  // Reads return the stored value, so a same-cycle update is seen one cycle later.
  assign if_pred_taken = bht_q[if_idx][1];
  assign ctr_cur       = bht_q[res_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (res_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
    end else if (is_br) begin
      bht_q[res_idx] <= ctr_next;
    end
  end

  assign mispredict    = is_br && (res_taken != res_pred_taken);
  assign redirect_pc_d = res_taken ? res_target : res_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) redirect_pc_q <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (stats_clr) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (is_br && (branch_cnt_q != CntMax))       branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != CntMax)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  assign unused_bits = ^{if_pc[XLEN-1:IdxW+2], if_pc[1:0], res_pc[XLEN-1:IdxW+2], res_pc[1:0],
                         res_inst[31:15], res_inst[11:7]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: compare table plus multi-cycle sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h100;
  logic        if_pred_taken;
  logic        res_valid = 1'b0;
  logic [31:0] res_inst = '0;
  logic [31:0] res_pc = '0, res_rs1 = '0, res_rs2 = '0, res_target = '0;
  logic        res_pred_taken = 1'b0;
  logic        res_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stats_clr = 1'b0;
  logic [31:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int passed = 0;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .res_valid     (res_valid),
    .res_inst      (res_inst),
    .res_pc        (res_pc),
    .res_rs1       (res_rs1),
    .res_rs2       (res_rs2),
    .res_target    (res_target),
    .res_pred_taken(res_pred_taken),
    .res_taken     (res_taken),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stats_clr     (stats_clr),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] tgt, input logic pred);
    res_valid      = 1'b1;
    res_inst       = mk_inst(f3, 7'b1100011);
    res_pc         = pc;
    res_rs1        = rs1;
    res_rs2        = rs2;
    res_target     = tgt;
    res_pred_taken = pred;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    res_valid = 1'b0;
    stats_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic edge_then_idle();
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] init_ctr;
    logic [3:0] pre_exp;
    init_ctr = 2'b01;
    pre_exp  = 4'b1110;

    vecs[0]  = '{3'b000, 32'd5,         32'd5,         1'b1};
    vecs[1]  = '{3'b000, 32'd5,         32'd6,         1'b0};
    vecs[2]  = '{3'b001, 32'd5,         32'd6,         1'b1};
    vecs[3]  = '{3'b110, 32'hFFFFFFFF,  32'd1,         1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFFF,  32'd1,         1'b1};
    vecs[5]  = '{3'b111, 32'h80000000,  32'h7FFFFFFF,  1'b1};
    vecs[6]  = '{3'b101, 32'h80000000,  32'h7FFFFFFF,  1'b0};
    vecs[7]  = '{3'b100, 32'h80000000,  32'h7FFFFFFF,  1'b1};
    vecs[8]  = '{3'b110, 32'd1,         32'hFFFFFFFF,  1'b1};
    vecs[9]  = '{3'b101, 32'd3,         32'd3,         1'b1};
    vecs[10] = '{3'b010, 32'd5,         32'd5,         1'b0};
    vecs[11] = '{3'b011, 32'd5,         32'd5,         1'b0};

    // Reset state
    #2;
    check("reset_redirect", 32'(redirect), 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_branch_cnt", branch_cnt, 32'd0);
    check("reset_mispred_cnt", mispred_cnt, 32'd0);
    check("reset_pred", 32'(if_pred_taken), 32'(init_ctr[1]));
    @(negedge clk);
    rst = 1'b0;

    // Compare table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_br(vecs[i].f3, 32'h40, vecs[i].rs1, vecs[i].rs2, 32'h0, 1'b0);
      #1;
      check($sformatf("cmp_vec%0d", i), 32'(res_taken), 32'(vecs[i].exp));
    end
    @(negedge clk);
    set_br(3'b000, 32'h40, 32'd5, 32'd5, 32'h0, 1'b0);
    res_valid = 1'b0;
    #1;
    check("cmp_invalid", 32'(res_taken), 32'd0);
    res_valid = 1'b1;
    res_inst  = mk_inst(3'b000, 7'b1101111);
    #1;
    check("cmp_not_branch", 32'(res_taken), 32'd0);

    // BEQ mispredict at 0x100 redirects to target
    do_reset();
    set_br(3'b000, 32'h100, 32'd5, 32'd5, 32'h80, 1'b0);
    #1;
    check("beq_taken", 32'(res_taken), 32'd1);
    check("beq_no_early_redirect", 32'(redirect), 32'd0);
    edge_then_idle();
    check("beq_redirect", 32'(redirect), 32'd1);
    check("beq_redirect_pc", redirect_pc, 32'h80);
    check("beq_branch_cnt", branch_cnt, 32'd1);
    check("beq_mispred_cnt", mispred_cnt, 32'd1);
    if_pc = 32'h100;
    #1;
    check("beq_bht_trained", 32'(if_pred_taken), 32'd1);
    @(posedge clk);
    #1;
    check("beq_pulse_one_cycle", 32'(redirect), 32'd0);
    check("beq_redirect_pc_hold", redirect_pc, 32'h80);

    // Counter saturation at 0x200, with same-cycle read returning pre-update value
    do_reset();
    if_pc = 32'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_br(3'b000, 32'h200, 32'd1, 32'd1, 32'h900, 1'b1);
      #1;
      check($sformatf("sat_taken_pre%0d", k), 32'(if_pred_taken), 32'(pre_exp[k]));
      edge_then_idle();
      check($sformatf("sat_taken_noredir%0d", k), 32'(redirect), 32'd0);
    end
    check("sat_after_taken", 32'(if_pred_taken), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_br(3'b001, 32'h200, 32'd1, 32'd1, 32'h900, 1'b1);
      edge_then_idle();
    end
    #1;
    check("sat_two_nt_weak_nt", 32'(if_pred_taken), 32'd0);
    check("sat_branch_cnt", branch_cnt, 32'd6);
    check("sat_mispred_cnt", mispred_cnt, 32'd2);

    // Correct prediction and illegal funct3
    @(negedge clk);
    set_br(3'b000, 32'h300, 32'd9, 32'd9, 32'hA00, 1'b1);
    edge_then_idle();
    check("correct_no_redirect", 32'(redirect), 32'd0);
    check("correct_branch_cnt", branch_cnt, 32'd7);
    check("correct_mispred_cnt", mispred_cnt, 32'd2);
    @(negedge clk);
    set_br(3'b010, 32'h300, 32'd9, 32'd9, 32'hA00, 1'b1);
    #1;
    check("f3_010_taken", 32'(res_taken), 32'd0);
    edge_then_idle();
    check("f3_010_no_redirect", 32'(redirect), 32'd0);
    check("f3_010_branch_cnt", branch_cnt, 32'd7);
    check("f3_010_mispred_cnt", mispred_cnt, 32'd2);

    // Clear wins over a same-cycle increment
    @(negedge clk);
    set_br(3'b000, 32'h300, 32'd1, 32'd2, 32'hA00, 1'b1);
    stats_clr = 1'b1;
    edge_then_idle();
    stats_clr = 1'b0;
    check("clr_branch_cnt", branch_cnt, 32'd0);
    check("clr_mispred_cnt", mispred_cnt, 32'd0);

    // Back-to-back mispredicts
    @(negedge clk);
    set_br(3'b000, 32'h400, 32'd1, 32'd1, 32'h800, 1'b0);
    @(posedge clk);
    #1;
    set_br(3'b001, 32'h500, 32'd1, 32'd1, 32'hC00, 1'b1);
    check("b2b_first_redirect", 32'(redirect), 32'd1);
    check("b2b_first_pc", redirect_pc, 32'h800);
    edge_then_idle();
    check("b2b_second_redirect", 32'(redirect), 32'd1);
    check("b2b_second_pc", redirect_pc, 32'h504);
    @(posedge clk);
    #1;
    check("b2b_idle_redirect", 32'(redirect), 32'd0);
    check("b2b_idle_pc_hold", redirect_pc, 32'h504);

    // Not-taken mispredict wraps PC+4
    @(negedge clk);
    set_br(3'b001, 32'hFFFFFFFC, 32'd2, 32'd2, 32'h1234, 1'b1);
    edge_then_idle();
    check("wrap_redirect", 32'(redirect), 32'd1);
    check("wrap_redirect_pc", redirect_pc, 32'h0);

    // Reset mid-cycle discards a pending redirect
    @(negedge clk);
    set_br(3'b000, 32'h600, 32'd7, 32'd7, 32'h123, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_redirect_pc", redirect_pc, 32'h0);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_no_late_pulse", 32'(redirect), 32'd0);
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check($sformatf("rst_bht%0d", i), 32'(if_pred_taken), 32'(init_ctr[1]));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC and operands.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit prediction counters; power of two, at least 2.
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, reset value of every counter.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_pc  input  XLEN  fetch-stage PC to predict.
REQ-007 SHALL have port if_pred_taken  output  1  prediction for if_pc.
REQ-008 SHALL have port res_valid  input  1  resolve-stage instruction valid.
REQ-009 SHALL have port res_inst  input  32  resolve-stage instruction word.
REQ-010 SHALL have port res_pc  input  XLEN  resolve-stage instruction PC.
REQ-011 SHALL have port res_rs1  input  XLEN  forwarded rs1 value.
REQ-012 SHALL have port res_rs2  input  XLEN  forwarded rs2 value.
REQ-013 SHALL have port res_target  input  XLEN  computed branch target.
REQ-014 SHALL have port res_pred_taken  input  1  prediction carried down the pipe with this instruction.
REQ-015 SHALL have port res_taken  output  1  combinational branch outcome.
REQ-016 SHALL have port redirect  output  1  registered mispredict redirect pulse.
REQ-017 SHALL have port redirect_pc  output  XLEN  registered correct-path PC.
REQ-018 SHALL have port stats_clr  input  1  synchronous clear of statistics counters.
REQ-019 SHALL have port branch_cnt  output  32  resolved conditional branches.
REQ-020 SHALL have port mispred_cnt  output  32  mispredicted conditional branches.

Function
REQ-021 SHALL flag is_br = res_valid, opcode res_inst[6:0] = 1100011, and funct3 res_inst[14:12] in {000,001,100,101,110,111}; funct3 010/011 gives is_br = 0.
REQ-022 SHALL compute res_taken directly from res_rs1/res_rs2: 000 equal, 001 not equal, 100 signed less-than, 101 signed greater-or-equal, 110 unsigned less-than, 111 unsigned greater-or-equal; res_taken = 0 when is_br = 0.
REQ-023 SHALL perform full-width compares (signed and unsigned) with no subtraction overflow error at any XLEN.
REQ-024 SHALL index the BHT with pc[log2(BHT_DEPTH)+1:2], both for if_pc and for res_pc.
REQ-025 SHALL drive if_pred_taken = bit[1] of the counter indexed by if_pc, combinationally.
REQ-026 SHALL update the counter at res_pc on each clock edge where is_br = 1: saturating increment on taken, saturating decrement on not taken.
REQ-027 SHALL use the counter states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; 11 stays 11 on taken, 00 stays 00 on not taken.
REQ-028 SHALL return the pre-update value on a same-cycle read and write to the same index; the new value is visible the following cycle.
REQ-029 SHALL assert redirect for exactly one cycle, on the edge after a cycle where is_br = 1 and res_taken != res_pred_taken.
REQ-030 SHALL set redirect_pc = res_target when the branch is taken, else res_pc + 4 (modulo 2^XLEN); redirect_pc holds its value when redirect = 0.
REQ-031 SHALL never assert redirect for non-branches, illegal funct3, or res_valid = 0.
REQ-032 SHALL produce back-to-back mispredicts as consecutive redirect pulses, each carrying its own redirect_pc.
REQ-033 SHALL increment branch_cnt for every is_br, and mispred_cnt for every mispredict, each saturating at 0xFFFFFFFF.
REQ-034 SHALL clear both counters to 0 on stats_clr; when stats_clr and an increment occur in the same cycle, the clear wins.

Reset
REQ-035 SHALL, while rst = 1 and independent of clk, set all BHT entries to CTR_INIT, redirect = 0, redirect_pc = 0, and both counters = 0.
REQ-036 SHALL discard a redirect pending from the cycle when reset asserts; no pulse appears after rst deasserts.

Verification
REQ-037 SHALL cover: after reset, BEQ with rs1 = rs2 = 5 at pc 0x100, pred 0 -> res_taken = 1; next cycle redirect = 1, redirect_pc = res_target = 0x80.
REQ-038 SHALL cover: BLTU with rs1 = 0xFFFFFFFF, rs2 = 1 -> not taken; BLT with the same operands -> taken; BGEU with 0x80000000 vs 0x7FFFFFFF -> taken.
REQ-039 SHALL cover: three taken branches at pc 0x200 from CTR_INIT 01 -> if_pred_taken for 0x200 reads 0 then 1 then 1; counter sits at 11, and a fourth taken keeps it at 11.
REQ-040 SHALL cover: correct prediction (pred 1, taken) -> no redirect, branch_cnt += 1, mispred_cnt unchanged; funct3 010 with opcode 1100011 -> no counter change and no redirect.
REQ-041 SHALL cover: not-taken mispredict at pc 0xFFFFFFFC -> redirect_pc = 0x00000000 (wrap).
REQ-042 SHALL cover: rst asserted mid-cycle after a mispredict -> redirect stays 0, counters read 0, and all BHT entries read back CTR_INIT.
